// File: rtl/nios_sd_loader_gpio.sv
// Avalon-MM bidirectional GPIO with configurable width, input synchroniser,
// edge capture with IRQ masking and atomic set/clear of output bits.
module nios_sd_loader_gpio #(
  parameter int unsigned           DATA_WIDTH  = 8,
  parameter int unsigned           SYNC_STAGES = 2,
  parameter int unsigned           EDGE_TYPE   = 0,
  parameter logic [DATA_WIDTH-1:0] DATA_RESET  = '0,
  parameter logic [DATA_WIDTH-1:0] DIR_RESET   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  inout  wire  [DATA_WIDTH-1:0] bidir_port,
  output logic                  irq
);

  typedef enum logic [2:0] {
    REG_DATA    = 3'd0,
    REG_DIR     = 3'd1,
    REG_IRQMASK = 3'd2,
    REG_EDGECAP = 3'd3,
    REG_OUTSET  = 3'd4,
    REG_OUTCLR  = 3'd5
  } reg_addr_e;

  logic [DATA_WIDTH-1:0]                  r_data_out;
  logic [DATA_WIDTH-1:0]                  r_data_dir;
  logic [DATA_WIDTH-1:0]                  r_irq_mask;
  logic [DATA_WIDTH-1:0]                  r_edge_cap;
  logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] r_sync;
  logic [DATA_WIDTH-1:0]                  r_prev;
  logic [31:0]                            r_readdata;

  logic                  w_wr;
  logic [DATA_WIDTH-1:0] w_wd;
  logic [DATA_WIDTH-1:0] w_sync_in;
  logic [DATA_WIDTH-1:0] w_event;
  logic [DATA_WIDTH-1:0] w_clr;
  logic [31:0]           w_rd;
  logic                  w_unused_wd;

  assign w_wr        = chipselect && !write_n;
  assign w_wd        = writedata[DATA_WIDTH-1:0];
  assign w_unused_wd = ^writedata;
  assign w_sync_in   = r_sync[SYNC_STAGES-1];
  assign w_clr       = (w_wr && address == REG_EDGECAP) ? w_wd : '0;

  genvar g;
  for (g = 0; g < DATA_WIDTH; g++) begin : g_pin
    assign bidir_port[g] = r_data_dir[g] ? r_data_out[g] : 1'bz;
  end

  always_comb begin
    w_event = '0;
    if (EDGE_TYPE == 0)
      w_event = w_sync_in & ~r_prev;
    else if (EDGE_TYPE == 1)
      w_event = ~w_sync_in & r_prev;
    else
      w_event = w_sync_in ^ r_prev;
  end

  always_comb begin
    w_rd = '0;
    case (address)
      REG_DATA:    w_rd[DATA_WIDTH-1:0] = w_sync_in;
      REG_DIR:     w_rd[DATA_WIDTH-1:0] = r_data_dir;
      REG_IRQMASK: w_rd[DATA_WIDTH-1:0] = r_irq_mask;
      REG_EDGECAP: w_rd[DATA_WIDTH-1:0] = r_edge_cap;
      default:     w_rd = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data_out <= DATA_RESET;
      r_data_dir <= DIR_RESET;
      r_irq_mask <= '0;
      r_edge_cap <= '0;
      r_sync     <= '0;
      r_prev     <= '0;
      r_readdata <= '0;
    end else begin
      r_sync[0] <= bidir_port;
      for (int unsigned s = 1; s < SYNC_STAGES; s++)
        r_sync[s] <= r_sync[s-1];
      r_prev     <= w_sync_in;
      r_readdata <= w_rd;
      // A new event outranks a same-cycle W1C on the same bit.
      r_edge_cap <= (r_edge_cap & ~w_clr) | w_event;
      if (w_wr) begin
        case (address)
          REG_DATA:    r_data_out <= w_wd;
          REG_DIR:     r_data_dir <= w_wd;
          REG_IRQMASK: r_irq_mask <= w_wd;
          REG_OUTSET:  r_data_out <= r_data_out | w_wd;
          REG_OUTCLR:  r_data_out <= r_data_out & ~w_wd;
          default:     ;
        endcase
      end
    end
  end

  assign readdata = r_readdata;
  assign irq      = |(r_edge_cap & r_irq_mask);

endmodule
